// File: rtl/pipeline_stage.sv
// Elastic pipeline register with valid/ready handshake, optional skid entry,
// synchronous flush and a saturating count of flushed entries.
module pipeline_stage #(
  parameter int DATA_W = 32,
  parameter int CTRL_W = 16,
  parameter int SKID   = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occupancy,
  output logic [7:0]        flush_drops
);

  typedef enum logic [1:0] {
    EMPTY    = 2'd0,
    FULL     = 2'd1,
    SKIDFULL = 2'd2
  } state_t;

  state_t state, state_next;

  logic [CTRL_W-1:0] main_ctrl, skid_ctrl;
  logic [DATA_W-1:0] main_data, skid_data;
  logic              do_accept, do_release;
  logic              load_main, load_main_from_skid, load_skid;
  logic [1:0]        drop_inc;
  logic [8:0]        drop_sum;

  // The skid variant keeps in_ready free of any path from out_ready.
  generate
    if (SKID != 0) begin : g_skid_ready
      assign in_ready = (state != SKIDFULL) && !flush && !rst;
    end else begin : g_pass_ready
      assign in_ready = ((state == EMPTY) || out_ready) && !flush && !rst;
    end
  endgenerate

  assign out_valid  = (state != EMPTY);
  assign out_ctrl   = out_valid ? main_ctrl : '0;
  assign out_data   = main_data;
  assign do_accept  = in_valid && in_ready;
  assign do_release = out_valid && out_ready;

  always_comb begin
    occupancy = 2'd0;
    case (state)
      FULL:     occupancy = 2'd1;
      SKIDFULL: occupancy = 2'd2;
      default:  occupancy = 2'd0;
    endcase
  end

  always_comb begin
    state_next          = state;
    load_main           = 1'b0;
    load_main_from_skid = 1'b0;
    load_skid           = 1'b0;
    case (state)
      EMPTY: begin
        if (do_accept) begin
          load_main  = 1'b1;
          state_next = FULL;
        end
      end
      FULL: begin
        if (do_accept && do_release) begin
          load_main = 1'b1;
        end else if (do_accept) begin
          if (SKID != 0) begin
            load_skid  = 1'b1;
            state_next = SKIDFULL;
          end else begin
            load_main = 1'b1;
          end
        end else if (do_release) begin
          state_next = EMPTY;
        end
      end
      SKIDFULL: begin
        if (do_release) begin
          load_main_from_skid = 1'b1;
          state_next          = FULL;
        end
      end
      default: state_next = EMPTY;
    endcase
    if (flush) begin
      state_next          = EMPTY;
      load_main           = 1'b0;
      load_main_from_skid = 1'b0;
      load_skid           = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= EMPTY;
    end else begin
      state <= state_next;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      main_ctrl <= '0;
      main_data <= '0;
      skid_ctrl <= '0;
      skid_data <= '0;
    end else if (flush) begin
      main_ctrl <= '0;
      main_data <= '0;
      skid_ctrl <= '0;
      skid_data <= '0;
    end else begin
      if (load_main) begin
        main_ctrl <= in_ctrl;
        main_data <= in_data;
      end else if (load_main_from_skid) begin
        main_ctrl <= skid_ctrl;
        main_data <= skid_data;
      end
      if (load_skid) begin
        skid_ctrl <= in_ctrl;
        skid_data <= in_data;
      end
    end
  end

  // An entry leaving downstream on the flushing edge is not a drop.
  assign drop_inc = occupancy - {1'b0, do_release};
  assign drop_sum = {1'b0, flush_drops} + {7'd0, drop_inc};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      flush_drops <= 8'd0;
    end else if (flush) begin
      flush_drops <= drop_sum[8] ? 8'd255 : drop_sum[7:0];
    end
  end

endmodule
